// File: rtl/serial_paralelo_alineador.sv
// serial_paralelo_alineador: MSB-first deserialiser with COM-based
// byte alignment feeding the 1:2 eight-bit demux stage.
module serial_paralelo_alineador #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int CW = $clog2(WIDTH);
    localparam int KW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        ACTIVE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    // Only the WIDTH-1 newest bits are needed to form the next symbol.
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-2:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [KW-1:0]    com_cnt_q;
    logic [KW-1:0]    com_cnt_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic             active_d;

    logic [WIDTH-1:0] cand;
    logic             is_com;
    logic             boundary;

    assign cand     = {shift_q, data_in};
    assign is_com   = (cand == COM);
    assign boundary = (cnt_q == CW'(WIDTH - 1));

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= SEARCH;
            shift_q   <= '0;
            cnt_q     <= '0;
            com_cnt_q <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            com_cnt_q <= com_cnt_d;
            data_out  <= data_out == data_d ? data_out : data_d;
            valid_out <= valid_d;
            active    <= active_d;
        end
    end

    // Next-state: bit hunt, boundary-checked lock, then symbol output.
    always_comb begin
        state_d   = state_q;
        shift_d   = cand[WIDTH-2:0];
        cnt_d     = boundary ? '0 : cnt_q + CW'(1);
        com_cnt_d = com_cnt_q;
        data_d    = data_out;
        valid_d   = valid_out;
        active_d  = active;

        unique case (state_q)
            SEARCH: begin
                if (is_com) begin
                    // Reload so the next boundary lands one symbol later.
                    cnt_d     = '0;
                    com_cnt_d = KW'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + KW'(1);
                        if (com_cnt_d == KW'(LOCK_COUNT)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_d  = cand;
                    valid_d = !is_com;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_alineador.sv
// tb_serial_paralelo_alineador: directed scenarios plus random streams
// checked every edge against a symbol-level reference model.
module tb_serial_paralelo_alineador;

    localparam logic [7:0] COM = 8'hBC;
    localparam int M_SEARCH = 0;
    localparam int M_ALIGN  = 1;
    localparam int M_LOCKED = 2;

    logic       clk_8f = 1'b0;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks   = 0;
    int failures = 0;

    // Reference model: sliding window of the last 8 bits, edge index,
    // and the edge index of the alignment anchor (the first COM match).
    logic [7:0] win;
    int         n;
    int         anchor;
    int         coms;
    int         mode;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    serial_paralelo_alineador dut (
        .clk_8f   (clk_8f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        win      = '0;
        n        = 0;
        anchor   = 0;
        coms     = 0;
        mode     = M_SEARCH;
        m_data   = '0;
        m_valid  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_step(input logic b);
        win = {win[6:0], b};
        n++;
        if (mode == M_SEARCH) begin
            if (win == COM) begin
                anchor = n;
                coms   = 1;
                mode   = M_ALIGN;
            end
        end else if ((n - anchor) % 8 == 0) begin
            if (mode == M_ALIGN) begin
                if (win == COM) begin
                    coms++;
                    if (coms == 4) begin
                        mode     = M_LOCKED;
                        m_active = 1'b1;
                    end
                end else begin
                    coms = 0;
                    mode = M_SEARCH;
                end
            end else begin
                m_data  = win;
                m_valid = (win != COM);
            end
        end
    endtask

    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk_8f);
        model_step(b);
        #1;
        check("edge", 32'({active, valid_out, data_out}),
              32'({m_active, m_valid, m_data}));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic pulse_reset();
        #2;
        reset_L = 1'b0;
        #1;
        check("rst_async", 32'({active, valid_out, data_out}), 32'd0);
        model_reset();
        #2;
        reset_L = 1'b1;
    endtask

    task automatic out_is(input string tag, input logic a,
                          input logic v, input logic [7:0] d);
        check(tag, 32'({active, valid_out, data_out}), 32'({a, v, d}));
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        reset_L = 1'b0;
        data_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_8f);
        #1;
        out_is("reset", 1'b0, 1'b0, 8'h00);
        #2;
        reset_L = 1'b1;

        // 1: idle zeros never lock
        repeat (16) tick(1'b0);
        out_is("s1_idle", 1'b0, 1'b0, 8'h00);

        // 2: junk, four COMs, payload
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        repeat (3) send_byte(COM);
        out_is("s2_pre_lock", 1'b0, 1'b0, 8'h00);
        send_byte(COM);
        out_is("s2_lock", 1'b1, 1'b0, 8'h00);
        send_byte(8'h5A);
        out_is("s2_data", 1'b1, 1'b1, 8'h5A);
        b = 8'h33;
        for (int i = 7; i >= 1; i--) tick(b[i]);
        out_is("s2_hold", 1'b1, 1'b1, 8'h5A);
        tick(b[0]);
        out_is("s3_data33", 1'b1, 1'b1, 8'h33);

        // 3: COM in ACTIVE is not valid, lock stays
        send_byte(COM);
        out_is("s3_com", 1'b1, 1'b0, COM);

        // 4: broken COM run falls back to search
        pulse_reset();
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h11);
        out_is("s4_broken", 1'b0, 1'b0, 8'h00);
        repeat (3) send_byte(COM);
        out_is("s4_pre_lock", 1'b0, 1'b0, 8'h00);
        send_byte(COM);
        out_is("s4_lock", 1'b1, 1'b0, 8'h00);

        // 5: reset mid-symbol while locked
        send_byte(8'h42);
        out_is("s5_locked", 1'b1, 1'b1, 8'h42);
        b = 8'hA5;
        for (int i = 7; i >= 5; i--) tick(b[i]);
        pulse_reset();
        repeat (3) send_byte(COM);
        out_is("s5_pre_relock", 1'b0, 1'b0, 8'h00);
        send_byte(COM);
        out_is("s5_relock", 1'b1, 1'b0, 8'h00);

        // 6: payload sequence after a fresh lock
        pulse_reset();
        repeat (4) send_byte(COM);
        send_byte(8'hFF);
        out_is("s6_ff", 1'b1, 1'b1, 8'hFF);
        send_byte(8'h00);
        out_is("s6_00", 1'b1, 1'b1, 8'h00);
        send_byte(8'hA5);
        out_is("s6_a5", 1'b1, 1'b1, 8'hA5);

        // Random streams with slips and resets, model-checked per edge
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                pulse_reset();
            end else if (r < 10) begin
                repeat ($urandom_range(1, 7)) tick(1'($urandom));
            end else if (r < 65) begin
                send_byte(COM);
            end else begin
                send_byte(8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
